// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states, opcodes, PC operations.
package control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_BZ    = 4'h9;
    localparam logic [3:0] OP_BNZ   = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_JUMP = 2'b10;

    // Codes B..E are reserved and decode as illegal.
    function automatic logic op_is_defined(input logic [3:0] op);
        return (op <= OP_BNZ) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the sequencer (master) and the datapath/memory side (slave).
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                flag;
    logic                mem_ready;

    logic                inst_wr;
    logic                decoder_en;
    logic                mem_rd;
    logic                mem_wr;
    logic                adrs_ctrl;
    logic                imm_en;
    logic                reg_en;
    logic                rD_wr;
    logic [1:0]          pc_op;
    logic                halted;
    logic                illegal;
    logic                bus_err;

    modport master (
        input  opcode, flag, mem_ready,
        output inst_wr, decoder_en, mem_rd, mem_wr, adrs_ctrl, imm_en,
               reg_en, rD_wr, pc_op, halted, illegal, bus_err
    );

    modport slave (
        output opcode, flag, mem_ready,
        input  inst_wr, decoder_en, mem_rd, mem_wr, adrs_ctrl, imm_en,
               reg_en, rD_wr, pc_op, halted, illegal, bus_err
    );
endinterface

// File: rtl/multicycle_control_unit_timer.sv
// Memory wait timer: counts stalled cycles, flags when the limit is reached.
// Latency: expired is a combinational compare of the registered count.
// Backpressure: none; clear has priority over count_en, count saturates at the limit.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] count_q;

    assign expired = (count_q == LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM driving fetch/decode/execute/memory/writeback enables.
// Latency: ALU/LOAD 4, STORE 3, branch/NOP 2 cycles plus one per memory wait cycle.
// Backpressure: FETCH/MEMORY hold until mem_ready; a stall reaching MEM_TIMEOUT goes to ERROR.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    multicycle_control_unit_if.master  bus
);
    state_t              state_q, state_d;
    logic [3:0]          op_q;
    logic                bus_err_q;
    logic                expired;
    logic                in_wait;
    logic [OPCODE_W-1:0] opcode_in;
    logic [3:0]          op_lo;
    logic                op_legal;

    logic       inst_wr_c, decoder_en_c, mem_rd_c, mem_wr_c, adrs_ctrl_c;
    logic       imm_en_c, reg_en_c, rD_wr_c, halted_c, illegal_c;
    logic [1:0] pc_op_c;

    assign opcode_in = bus.opcode;
    assign op_lo     = opcode_in[3:0];
    assign op_legal  = ((opcode_in >> 4) == '0) && op_is_defined(op_lo);
    assign in_wait   = (state_q == ST_FETCH) || (state_q == ST_MEMORY);

    // Leaving a wait state or completing a request restarts the count.
    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (!in_wait || bus.mem_ready),
        .count_en (in_wait && !bus.mem_ready),
        .expired  (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            op_q      <= OP_NOP;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= op_lo;
            end
            if (state_d == ST_ERROR) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        inst_wr_c    = 1'b0;
        decoder_en_c = 1'b0;
        mem_rd_c     = 1'b0;
        mem_wr_c     = 1'b0;
        adrs_ctrl_c  = 1'b0;
        imm_en_c     = 1'b0;
        reg_en_c     = 1'b0;
        rD_wr_c      = 1'b0;
        halted_c     = 1'b0;
        illegal_c    = 1'b0;
        pc_op_c      = PC_HOLD;

        case (state_q)
            ST_FETCH: begin
                mem_rd_c = 1'b1;
                if (bus.mem_ready) begin
                    inst_wr_c = 1'b1;
                    pc_op_c   = PC_INC;
                    state_d   = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                decoder_en_c = 1'b1;
                state_d      = ST_FETCH;
                if (!op_legal) begin
                    illegal_c = 1'b1;
                end else begin
                    case (op_lo)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_d = ST_EXECUTE;
                        OP_LOAD, OP_STORE:                      state_d = ST_MEMORY;
                        OP_JMP:                                 pc_op_c = PC_JUMP;
                        OP_BZ:   if (bus.flag)                  pc_op_c = PC_JUMP;
                        OP_BNZ:  if (!bus.flag)                 pc_op_c = PC_JUMP;
                        OP_HALT:                                state_d = ST_HALT;
                        OP_NOP:                                 state_d = ST_FETCH;
                        default:                                state_d = ST_FETCH;
                    endcase
                end
            end
            ST_EXECUTE: begin
                reg_en_c = 1'b1;
                imm_en_c = (op_q == OP_ADDI);
                state_d  = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                adrs_ctrl_c = 1'b1;
                mem_rd_c    = (op_q == OP_LOAD);
                mem_wr_c    = (op_q == OP_STORE);
                if (bus.mem_ready) begin
                    state_d = (op_q == OP_LOAD) ? ST_WRITEBACK : ST_FETCH;
                end else if (expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WRITEBACK: begin
                rD_wr_c = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted_c = 1'b1;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held, not just after the next edge.
    assign bus.inst_wr    = reset & inst_wr_c;
    assign bus.decoder_en = reset & decoder_en_c;
    assign bus.mem_rd     = reset & mem_rd_c;
    assign bus.mem_wr     = reset & mem_wr_c;
    assign bus.adrs_ctrl  = reset & adrs_ctrl_c;
    assign bus.imm_en     = reset & imm_en_c;
    assign bus.reg_en     = reset & reg_en_c;
    assign bus.rD_wr      = reset & rD_wr_c;
    assign bus.halted     = reset & halted_c;
    assign bus.illegal    = reset & illegal_c;
    assign bus.pc_op      = reset ? pc_op_c : PC_HOLD;
    assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-level scoreboard bench: each driven cycle queues its expected output vector.
module tb_multicycle_control_unit;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    multicycle_control_unit_if #(.OPCODE_W(5)) bus ();

    multicycle_control_unit #(
        .OPCODE_W    (5),
        .MEM_TIMEOUT (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // {inst_wr, decoder_en, mem_rd, mem_wr, adrs_ctrl, imm_en, reg_en, rD_wr, pc_op[1:0], halted, illegal, bus_err}
    localparam logic [12:0] NONE  = 13'h0000;
    localparam logic [12:0] INST  = 13'h1000;
    localparam logic [12:0] DEC   = 13'h0800;
    localparam logic [12:0] MRD   = 13'h0400;
    localparam logic [12:0] MWR   = 13'h0200;
    localparam logic [12:0] ADR   = 13'h0100;
    localparam logic [12:0] IMM   = 13'h0080;
    localparam logic [12:0] REG   = 13'h0040;
    localparam logic [12:0] RDW   = 13'h0020;
    localparam logic [12:0] PCJMP = 13'h0010;
    localparam logic [12:0] PCINC = 13'h0008;
    localparam logic [12:0] HLT   = 13'h0004;
    localparam logic [12:0] ILL   = 13'h0002;
    localparam logic [12:0] BERR  = 13'h0001;
    localparam logic [12:0] F_OK  = INST | MRD | PCINC;

    logic [12:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [12:0] mon_exp;
    logic [12:0] mon_got;
    string       mon_tag;

    task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_got = {bus.inst_wr, bus.decoder_en, bus.mem_rd, bus.mem_wr, bus.adrs_ctrl,
                       bus.imm_en, bus.reg_en, bus.rD_wr, bus.pc_op, bus.halted,
                       bus.illegal, bus.bus_err};
            check_eq(mon_tag, mon_got, mon_exp);
        end
    end

    task automatic cyc(input logic rst, input logic [4:0] op, input logic flg,
                       input logic rdy, input logic [12:0] exp, input string tag);
        @(posedge clock);
        #1;
        reset         = rst;
        bus.opcode    = op;
        bus.flag      = flg;
        bus.mem_ready = rdy;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    logic [4:0]  br_op  [6] = '{5'h09, 5'h09, 5'h0A, 5'h0A, 5'h08, 5'h00};
    logic        br_flg [6] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
    logic [12:0] br_exp [6] = '{DEC | PCJMP, DEC, DEC, DEC | PCJMP, DEC | PCJMP, DEC};
    logic [4:0]  ill_op [4] = '{5'h0C, 5'h11, 5'h0B, 5'h0E};

    initial begin
        bus.opcode    = '0;
        bus.flag      = 1'b0;
        bus.mem_ready = 1'b1;

        repeat (3) cyc(1'b0, 5'h00, 1'b0, 1'b1, NONE, "reset_low");

        cyc(1'b1, 5'h05, 1'b0, 1'b1, F_OK,      "addi_fetch");
        cyc(1'b1, 5'h05, 1'b0, 1'b0, DEC,       "addi_decode");
        cyc(1'b1, 5'h05, 1'b0, 1'b0, REG | IMM, "addi_exec");
        cyc(1'b1, 5'h05, 1'b0, 1'b0, RDW,       "addi_wb");

        // Opcode input changes after DECODE; EXECUTE must keep the latched ADD.
        cyc(1'b1, 5'h01, 1'b0, 1'b1, F_OK, "add_fetch");
        cyc(1'b1, 5'h01, 1'b0, 1'b0, DEC,  "add_decode");
        cyc(1'b1, 5'h05, 1'b0, 1'b0, REG,  "add_exec_latched");
        cyc(1'b1, 5'h05, 1'b0, 1'b0, RDW,  "add_wb");

        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, br_op[i], br_flg[i], 1'b1, F_OK,      "branch_fetch");
            cyc(1'b1, br_op[i], br_flg[i], 1'b0, br_exp[i], "branch_decode");
        end

        cyc(1'b1, 5'h06, 1'b0, 1'b1, F_OK, "load_fetch");
        cyc(1'b1, 5'h06, 1'b0, 1'b0, DEC,  "load_decode");
        repeat (3) cyc(1'b1, 5'h07, 1'b0, 1'b0, MRD | ADR, "load_wait");
        cyc(1'b1, 5'h07, 1'b0, 1'b1, MRD | ADR, "load_done");
        cyc(1'b1, 5'h07, 1'b0, 1'b0, RDW,       "load_wb");

        cyc(1'b1, 5'h07, 1'b0, 1'b1, F_OK,      "store_fetch");
        cyc(1'b1, 5'h07, 1'b0, 1'b0, DEC,       "store_decode");
        cyc(1'b1, 5'h07, 1'b0, 1'b1, MWR | ADR, "store_mem");

        repeat (2) cyc(1'b1, 5'h00, 1'b0, 1'b0, MRD, "fetch_wait");
        cyc(1'b1, 5'h00, 1'b0, 1'b1, F_OK, "fetch_done");
        cyc(1'b1, 5'h00, 1'b0, 1'b0, DEC,  "nop_decode");

        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, ill_op[i], 1'b0, 1'b1, F_OK,      "illegal_fetch");
            cyc(1'b1, ill_op[i], 1'b0, 1'b0, DEC | ILL, "illegal_decode");
        end

        // Ready on the fifth stalled cycle beats the timeout.
        repeat (4) cyc(1'b1, 5'h00, 1'b0, 1'b0, MRD, "limit_wait");
        cyc(1'b1, 5'h00, 1'b0, 1'b1, F_OK, "limit_ready");
        cyc(1'b1, 5'h00, 1'b0, 1'b0, DEC,  "limit_decode");

        repeat (5) cyc(1'b1, 5'h00, 1'b0, 1'b0, MRD, "fetch_timeout_wait");
        repeat (3) cyc(1'b1, 5'h00, 1'b0, 1'b1, BERR, "fetch_timeout_error");
        cyc(1'b0, 5'h00, 1'b0, 1'b1, NONE, "error_reset");
        cyc(1'b1, 5'h00, 1'b0, 1'b1, F_OK, "error_restart");
        cyc(1'b1, 5'h00, 1'b0, 1'b0, DEC,  "error_restart_decode");

        cyc(1'b1, 5'h06, 1'b0, 1'b1, F_OK, "mem_timeout_fetch");
        cyc(1'b1, 5'h06, 1'b0, 1'b0, DEC,  "mem_timeout_decode");
        repeat (5) cyc(1'b1, 5'h06, 1'b0, 1'b0, MRD | ADR, "mem_timeout_wait");
        repeat (2) cyc(1'b1, 5'h06, 1'b0, 1'b1, BERR, "mem_timeout_error");
        cyc(1'b0, 5'h00, 1'b0, 1'b1, NONE, "mem_error_reset");
        cyc(1'b1, 5'h00, 1'b0, 1'b1, F_OK, "mem_error_restart");
        cyc(1'b1, 5'h00, 1'b0, 1'b0, DEC,  "mem_error_decode");

        cyc(1'b1, 5'h0F, 1'b0, 1'b1, F_OK, "halt_fetch");
        cyc(1'b1, 5'h0F, 1'b0, 1'b0, DEC,  "halt_decode");
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1, HLT, "halt_hold");
        end
        cyc(1'b0, 5'h00, 1'b0, 1'b1, NONE, "halt_reset");
        cyc(1'b1, 5'h00, 1'b0, 1'b1, F_OK, "halt_restart");
        cyc(1'b1, 5'h00, 1'b0, 1'b0, DEC,  "halt_restart_decode");

        // Reset during a STORE's MEMORY cycle must not leave a write pending.
        cyc(1'b1, 5'h07, 1'b0, 1'b1, F_OK, "mid_fetch");
        cyc(1'b1, 5'h07, 1'b0, 1'b0, DEC,  "mid_decode");
        cyc(1'b0, 5'h07, 1'b0, 1'b1, NONE, "mid_reset");
        cyc(1'b1, 5'h07, 1'b0, 1'b0, MRD,  "mid_restart_wait");
        cyc(1'b1, 5'h07, 1'b0, 1'b1, F_OK, "mid_restart_fetch");
        cyc(1'b1, 5'h07, 1'b0, 1'b0, DEC,  "mid_restart_decode");

        repeat (2) @(negedge clock);
        #1;
        check_eq("queue_drained", 13'(exp_q.size()), 13'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multicycle control FSM for the task CPU datapath, the next generation of the existing fixed five-signal sequencer. It adds a memory ready/wait handshake with a timeout, conditional branches on `flag`, immediate ALU ops, a HALT state and illegal-opcode reporting. It sits between instruction memory/data memory, the decoder, the register file and the PC unit, and drives their enables every cycle.

## Interface
- `OPCODE_W`, 4: opcode width, ≥4. Bits above [3] must be zero, otherwise the opcode is illegal.
- `MEM_TIMEOUT`, 15: maximum cycles a memory request may wait for `mem_ready` (≥1).
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state and outputs are cleared while low
- `opcode`  in  OPCODE_W  instruction opcode from the instruction register, valid in DECODE
- `flag`  in  1  ALU zero flag, sampled in DECODE
- `mem_ready`  in  1  memory completes the current request this cycle
- `inst_wr`  out  1  load instruction register
- `decoder_en`  out  1  decoder enable
- `mem_rd` / `mem_wr`  out  1 each  memory read/write request
- `adrs_ctrl`  out  1  address select: 0 = PC, 1 = ALU/data address
- `imm_en`  out  1  ALU operand B = immediate
- `reg_en`  out  1  ALU/register read enable
- `rD_wr`  out  1  destination register write
- `pc_op`  out  2  00 HOLD, 01 INC, 10 JUMP; 11 is never driven
- `halted`  out  1  FSM in HALT
- `illegal`  out  1  one-cycle pulse in DECODE for an undefined opcode
- `bus_err`  out  1  sticky memory timeout flag; cleared only by reset

## Operation
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 ADDI; 6 LOAD; 7 STORE; 8 JMP; 9 BZ (taken if `flag`=1); A BNZ (taken if `flag`=0); F HALT.
  - B–E and any opcode with nonzero upper bits are illegal and behave as NOP.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, ERROR.
- FETCH: `mem_rd`=1, `adrs_ctrl`=0.
  - With `mem_ready`=1 in the same cycle: `inst_wr`=1, `pc_op`=INC, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: `decoder_en`=1.
  - ALU ops and ADDI → EXECUTE.
  - LOAD/STORE → MEMORY.
  - JMP, or a taken BZ/BNZ: `pc_op`=JUMP this cycle → FETCH.
  - Not-taken branch, NOP or illegal → FETCH.
  - HALT → HALT.
- EXECUTE: `reg_en`=1, `imm_en`=1 for ADDI only → WRITEBACK.
- MEMORY: `adrs_ctrl`=1, with `mem_rd`=1 for LOAD or `mem_wr`=1 for STORE. The request is held until `mem_ready`. Then LOAD → WRITEBACK and STORE → FETCH.
- WRITEBACK: `rD_wr`=1 → FETCH.
- HALT: `halted`=1; all other outputs 0. Exit only by reset.
- ERROR: `bus_err`=1; all other outputs 0. Exit only by reset.
- Wait timer:
  - Counts cycles spent in FETCH or MEMORY with `mem_ready`=0.
  - Clears on entering either state and on every `mem_ready`=1.
  - When the count reaches `MEM_TIMEOUT` and `mem_ready` is still 0 → ERROR next cycle.
  - `mem_ready` arriving in the same cycle as the limit wins: normal completion.
- Opcode latch: latched into an internal register on DECODE, so EXECUTE/MEMORY/WRITEBACK are immune to `opcode` changes.
- Outputs not listed for a state are 0.

## Timing
- Reset values:
  - State = FETCH.
  - Every output = 0 (`pc_op`=00) while `reset` is low.
  - Outputs of FETCH are driven from the first cycle after `reset` rises.
- Outputs:
  - All outputs are combinational from state, latched opcode, `flag` and `mem_ready`.
  - `inst_wr` and the MEMORY→next transition depend on same-cycle `mem_ready`.
- Latency with zero-wait memory:
  - ALU/ADDI and LOAD: 4 cycles.
  - STORE: 3 cycles.
  - JMP/branch/NOP: 2 cycles.
  - Each wait cycle adds 1 cycle.
- Reset asserted mid-instruction:
  - The FSM returns to FETCH immediately.
  - No partial `rD_wr`/`mem_wr` pulse is generated afterwards.

## Structure
- Package `control_pkg`:
  - state enum (3 bits)
  - opcode constants
  - `pc_op` constants HOLD/INC/JUMP
- Sub-module `mem_wait_timer`:
  - counter of width $clog2(MEM_TIMEOUT+1)
  - inputs: clear, count enable
  - output: `expired`
- The top level holds the FSM, opcode latch, output decode and `bus_err` flop.

## Test plan
- Reset low for 3 cycles with `mem_ready`=1 → all outputs 0. After release: FETCH with `mem_rd`=1, `inst_wr`=1, `pc_op`=01.
- ADDI, zero-wait → 4 cycles:
  - `inst_wr`
  - `decoder_en`
  - `reg_en` with `imm_en`=1
  - `rD_wr`
  - FETCH again in cycle 5.
- BZ with `flag`=1 → `pc_op`=10 in DECODE. BZ with `flag`=0 → `pc_op`=00 in DECODE. Both are back in FETCH in cycle 3.
- LOAD with `mem_ready` low for 3 cycles in MEMORY → `mem_rd`=1 and `adrs_ctrl`=1 held 4 cycles, then `rD_wr`=1.
- `MEM_TIMEOUT`=4, `mem_ready` stuck 0 in FETCH → ERROR after 5 FETCH cycles, `bus_err`=1 sticky until reset. Repeat with `mem_ready`=1 on cycle 5 → normal DECODE.
- Opcode 0xC → `illegal` pulses 1 cycle, then FETCH. Opcode 0xF → `halted`=1 held for 20 cycles until reset.
